scan_sequencer: RTL

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

---
 rtl/scan_sequencer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/scan_sequencer.sv
// scan_sequencer
// Walks through the channels of a scan frame. A priority encoder
// (priority_fsm) holds the set of channels still to be scanned. This block
// arms it with the frame mask and presents each remaining channel to a
// downstream coder through a valid/ready handshake. It then dumps the channel
// from the encoder and repeats until the encoder reports that it is empty.
//
// Configuration macro: SCAN_TIMEOUT_EN
//   If this macro is defined, a channel that waits TIMEOUT_CYC cycles without
//   ready is skipped and the sticky err_o flag sets.
//   If it is undefined, PRESENT waits indefinitely and err_o is tied low.
//
// Parameters
//   TIMEOUT_CYC  maximum cycles ch_valid_o waits for ch_ready_i (timeout build only)
//   CNT_W        width of frame_cnt_o
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   start_i             request to begin a frame (accepted only in IDLE)
//   abort_i             return to IDLE from any active state
//   ch_mask_i[15:0]     channels to scan, captured when start_i is accepted
//   fsm_ch_sel_o[15:0]  captured mask, fed to priority_fsm ch_sel_i
//   fsm_arm_o           load pulse to priority_fsm
//   fsm_dump_o          remove-current-channel pulse to priority_fsm
//   fsm_ch_sel_i[15:0]  one-hot current channel from priority_fsm
//   fsm_zero_i          priority_fsm has no channels left
//   ch_valid_o          ch_idx_o is being offered downstream
//   ch_idx_o[3:0]       binary index of the offered channel
//   ch_ready_i          downstream accepts ch_idx_o
//   busy_o              frame in progress
//   frame_done_o        pulse at normal frame completion
//   frame_cnt_o         completed frame count (wraps)
//   err_o               sticky timeout flag
module scan_sequencer #(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [15:0]      ch_mask_i,
  output logic [15:0]      fsm_ch_sel_o,
  output logic             fsm_arm_o,
  output logic             fsm_dump_o,
  input  logic [15:0]      fsm_ch_sel_i,
  input  logic             fsm_zero_i,
  output logic             ch_valid_o,
  output logic [3:0]       ch_idx_o,
  input  logic             ch_ready_i,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic             err_o
);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SETTLE,
    PRESENT,
    DUMP,
    CHECK,
    DONE
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [3:0] low_idx;
  logic       timeout;
  logic       accept_start;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("scan_sequencer: TIMEOUT_CYC must be at least 1");
  end

  assign accept_start = (state == IDLE) && start_i && !abort_i;

  // Lowest set bit of the encoder's one-hot output. The scan goes from high
  // to low so that the lowest set bit is the last value written.
  always_comb begin
    low_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (fsm_ch_sel_i[i]) begin
        low_idx = 4'(i);
      end
    end
  end

`ifdef SCAN_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TMO_W-1:0] tmo_cnt;

  // Counts the cycles in PRESENT that pass without ready. The count restarts
  // each time the FSM enters PRESENT, so each channel gets a full window.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt <= '0;
    end else if (state != PRESENT) begin
      tmo_cnt <= '0;
    end else if (!ch_ready_i) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign timeout = (state == PRESENT) && !ch_ready_i &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  // Abort wins over a timeout that happens in the same cycle, so the error
  // flag only records timeouts that actually skipped a channel.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (timeout && !abort_i) begin
      err_o <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // SETTLE and CHECK each give priority_fsm one cycle to update after an arm
  // or dump pulse, before zero_o is trusted. Abort takes priority over every
  // other transition, including a handshake in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept_start) next_state = ARM;
      ARM:     next_state = SETTLE;
      SETTLE:  next_state = fsm_zero_i ? DONE : PRESENT;
      PRESENT: if (ch_ready_i || timeout) next_state = DUMP;
      DUMP:    next_state = CHECK;
      CHECK:   next_state = fsm_zero_i ? DONE : PRESENT;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (abort_i && (state != IDLE)) begin
      next_state = IDLE;
    end
  end

  assign fsm_arm_o    = (state == ARM);
  assign fsm_dump_o   = (state == DUMP);
  assign ch_valid_o   = (state == PRESENT);
  assign busy_o       = (state != IDLE);
  assign frame_done_o = (state == DONE);

  // The channel index is captured on entry to PRESENT. This keeps it constant
  // for the whole handshake, even if the encoder inputs move.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fsm_ch_sel_o <= '0;
      ch_idx_o     <= '0;
      frame_cnt_o  <= '0;
    end else begin
      if (accept_start) begin
        fsm_ch_sel_o <= ch_mask_i;
      end
      if ((next_state == PRESENT) && (state != PRESENT)) begin
        ch_idx_o <= low_idx;
      end
      if ((state == DONE) && !abort_i) begin
        frame_cnt_o <= frame_cnt_o + 1'b1;
      end
    end
  end

endmodule
